// File: rtl/torect_seq.sv
// torect_seq: iterative CORDIC polar-to-rectangular converter.
//
// Converts an unsigned magnitude and a 16-bit binary phase into signed X/Y
// components, x ~= (mag/2)*cos(phase), y ~= (mag/2)*sin(phase). One CORDIC
// micro-rotation is applied per clock. The datapath is one shared x/y adder
// pair, one angle adder and a small arctangent ROM.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_valid, o_ready  request handshake; o_ready is high only in IDLE
//   i_mag             unsigned magnitude
//   i_phase           binary phase, 2^16 = one full turn
//   i_aux             tag carried with the sample
//   o_valid           one-cycle result strobe
//   o_x, o_y          signed results, held until the next result
//   o_aux             tag of the sample that produced o_x/o_y
module torect_seq #(
  parameter int ITER = 16,
  parameter int AW   = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [15:0]        i_mag,
  input  logic [15:0]        i_phase,
  input  logic [AW-1:0]      i_aux,
  output logic               o_valid,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic [AW-1:0]      o_aux
);

  localparam int XW = 21;  // x/y: signed, 4 fraction bits
  // The quadrant residual spans [0, 2^20) on the 2^22-per-turn scale, so one
  // extra bit keeps its sign bit clear until the first rotation.
  localparam int ZW = 21;
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // round(atan(2^-i) * 2^22 / (2*pi))
  localparam logic [19:0] ATAN [16] = '{
    20'd524288, 20'd309505, 20'd163534, 20'd83012,
    20'd41667,  20'd20854,  20'd10430,  20'd5215,
    20'd2608,   20'd1304,   20'd652,    20'd326,
    20'd163,    20'd81,     20'd41,     20'd20
  };

  typedef enum logic [1:0] {S_IDLE, S_GAIN, S_ROT, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [15:0]           mag_q, mag_d;
  logic [15:0]           phase_q, phase_d;
  logic [AW-1:0]         aux_q, aux_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [15:0]    ox_q, ox_d, oy_q, oy_d;
  logic [AW-1:0]         oaux_q, oaux_d;

  // Round half-up at the 4-bit fraction, then clamp to 16-bit signed.
  function automatic logic signed [15:0] sat_rnd(input logic signed [XW-1:0] v);
    logic signed [XW:0] t;
    t = (XW+1)'(v) + (XW+1)'(8);
    t = t >>> 4;
    if (t > (XW+1)'(32767))
      sat_rnd = 16'sh7FFF;
    else if (t < -(XW+1)'(32768))
      sat_rnd = 16'sh8000;
    else
      sat_rnd = t[15:0];
  endfunction

  // Gain pre-scale: 19898/65536 ~= 0.5/K, so the CORDIC growth K lands the
  // result at mag/2. m <= 19897 fits comfortably in the x/y integer part.
  logic [15:0]          m;
  logic signed [XW-1:0] mx;
  logic signed [XW-1:0] x_init, y_init;
  logic signed [ZW-1:0] z_init;

  assign m      = 16'(({16'd0, mag_q} * 32'd19898) >> 16);
  assign mx     = {1'b0, m, 4'b0000};
  assign z_init = {1'b0, phase_q[13:0], 6'b000000};

  // Quadrant pre-rotation leaves a residual angle in [0, 90 deg).
  always_comb begin
    x_init = '0;
    y_init = '0;
    case (phase_q[15:14])
      2'b00:   x_init = mx;
      2'b01:   y_init = mx;
      2'b10:   x_init = -mx;
      default: y_init = -mx;
    endcase
  end

  // Shared micro-rotation datapath.
  logic signed [XW-1:0] xs, ys, x_rot, y_rot;
  logic signed [ZW-1:0] a_ext, z_rot;
  logic                 dir;

  assign xs    = x_q >>> cnt_q;
  assign ys    = y_q >>> cnt_q;
  assign a_ext = {1'b0, ATAN[cnt_q]};
  assign dir   = ~z_q[ZW-1];  // rotate counter-clockwise while z >= 0
  assign x_rot = dir ? (x_q - ys) : (x_q + ys);
  assign y_rot = dir ? (y_q + xs) : (y_q - xs);
  assign z_rot = dir ? (z_q - a_ext) : (z_q + a_ext);

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    aux_d   = aux_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oaux_d  = oaux_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          mag_d   = i_mag;
          phase_d = i_phase;
          aux_d   = i_aux;
          state_d = S_GAIN;
        end
      end
      S_GAIN: begin
        x_d     = x_init;
        y_d     = y_init;
        z_d     = z_init;
        cnt_d   = '0;
        state_d = S_ROT;
      end
      S_ROT: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CW'(1);
        // Results are registered off the final rotation so they are already
        // stable while o_valid is high in OUT.
        if (cnt_q == LAST) begin
          ox_d    = sat_rnd(x_rot);
          oy_d    = sat_rnd(y_rot);
          oaux_d  = aux_q;
          state_d = S_OUT;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      phase_q <= '0;
      aux_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oaux_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
      aux_q   <= aux_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oaux_q  <= oaux_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_OUT);
  assign o_x     = ox_q;
  assign o_y     = oy_q;
  assign o_aux   = oaux_q;

endmodule

// File: tb/tb_torect_seq.sv
// Directed bench for torect_seq: reset values, axis/diagonal vectors,
// latency and handshake, back-to-back throughput, mid-conversion reset,
// zero magnitude, and a phase sweep against a real-valued model.
module tb_torect_seq;
  localparam int AW = 4;
  localparam real PI = 3.14159265358979323846;

  logic               i_clk = 1'b0;
  logic               i_reset, i_valid;
  logic               o_ready, o_valid;
  logic [15:0]        i_mag, i_phase;
  logic [AW-1:0]      i_aux;
  logic signed [15:0] o_x, o_y;
  logic [AW-1:0]      o_aux;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  torect_seq #(.ITER(16), .AW(AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_mag(i_mag), .i_phase(i_phase), .i_aux(i_aux), .o_valid(o_valid),
    .o_x(o_x), .o_y(o_y), .o_aux(o_aux)
  );

  function automatic real rabs(input real v);
    rabs = (v < 0.0) ? -v : v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Issue one request from IDLE and wait (bounded) for its strobe. lat is the
  // number of cycles after the accept edge, -1 on timeout.
  task automatic run_req(input logic [15:0] mag, input logic [15:0] ph,
                         input logic [AW-1:0] tag, output int rx, output int ry,
                         output logic [AW-1:0] raux, output int lat);
    lat = -1; rx = 0; ry = 0; raux = '0;
    @(negedge i_clk);
    i_valid = 1'b1; i_mag = mag; i_phase = ph; i_aux = tag;
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (o_valid) begin
        rx = int'(o_x); ry = int'(o_y); raux = o_aux; lat = c;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_mag = '0; i_phase = '0; i_aux = '0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_x !== 16'sd0) begin errors++; $display("FAIL reset_x got %0d want 0", o_x); end
    checks++; if (o_y !== 16'sd0) begin errors++; $display("FAIL reset_y got %0d want 0", o_y); end
    checks++; if (o_aux !== '0) begin errors++; $display("FAIL reset_aux got %0h want 0", o_aux); end
    i_reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] mags [8] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000};
    logic [15:0] phs  [8] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hA000, 16'h0000, 16'hFFFF};
    int xlo [8] = '{ 16381,    -3, -16387,     -3,  23167, -23173, 32765, 16381};
    int xhi [8] = '{ 16387,     3, -16381,      3,  23173, -23167, 32767, 16387};
    int ylo [8] = '{    -3, 16381,     -3, -16387,  23167, -23173,    -3,    -4};
    int yhi [8] = '{     3, 16387,      3, -16381,  23173, -23167,     3,     1};
    int rx, ry, lat;
    logic [AW-1:0] ra;
    for (int k = 0; k < 8; k++) begin
      run_req(mags[k], phs[k], AW'(k), rx, ry, ra, lat);
      checks++;
      if (lat != 18) begin
        errors++; $display("FAIL dir%0d_latency got %0d want 18", k, lat);
      end else begin
        checks++;
        if (rx < xlo[k] || rx > xhi[k]) begin
          errors++; $display("FAIL dir%0d_x got %0d want %0d..%0d", k, rx, xlo[k], xhi[k]);
        end
        checks++;
        if (ry < ylo[k] || ry > yhi[k]) begin
          errors++; $display("FAIL dir%0d_y got %0d want %0d..%0d", k, ry, ylo[k], yhi[k]);
        end
      end
    end
  endtask

  task automatic test_latency_handshake();
    int ready_bad = 0, first_v = -1, nvalid = 0, hx = 0, hy = 0, hold_x = 0;
    logic ready19 = 1'b0;
    logic [AW-1:0] cap_aux = '0;
    @(negedge i_clk);
    i_valid = 1'b1; i_mag = 16'h8000; i_phase = 16'h1000; i_aux = 4'hA;
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c <= 18 && o_ready !== 1'b0) ready_bad++;
      if (o_valid === 1'b1) begin
        nvalid++;
        if (first_v < 0) begin
          first_v = c; hx = int'(o_x); hy = int'(o_y); cap_aux = o_aux;
        end
      end
      if (c == 19) ready19 = o_ready;
      if (c == 30) hold_x = int'(o_x);
      // Requests while busy (ROT and OUT) must be dropped.
      i_valid = (c == 5 || c == 18) ? 1'b1 : 1'b0;
      i_mag = 16'h1234; i_phase = 16'h5000; i_aux = 4'h3;
      @(negedge i_clk);
    end
    checks++; if (first_v != 18) begin errors++; $display("FAIL lat_valid_cycle got %0d want 18", first_v); end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL lat_valid_count got %0d want 1", nvalid); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL lat_ready_low got %0d high cycles want 0", ready_bad); end
    checks++; if (ready19 !== 1'b1) begin errors++; $display("FAIL lat_ready_return got %b want 1", ready19); end
    checks++; if (cap_aux !== 4'hA) begin errors++; $display("FAIL lat_aux got %0h want a", cap_aux); end
    // 22.5 deg at radius 16384: (15137, 6270)
    checks++; if (hx < 15134 || hx > 15140) begin errors++; $display("FAIL lat_x got %0d want 15134..15140", hx); end
    checks++; if (hy < 6267 || hy > 6273) begin errors++; $display("FAIL lat_y got %0d want 6267..6273", hy); end
    checks++; if (hold_x != hx) begin errors++; $display("FAIL lat_hold_x got %0d want %0d", hold_x, hx); end
  endtask

  task automatic test_back_to_back();
    int vpos [4] = '{-1, -1, -1, -1};
    int nv = 0;
    logic rdy19 = 1'b0, rdy38 = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1; i_mag = 16'h4000; i_phase = 16'h0800; i_aux = 4'h5;
    for (int c = 1; c <= 60; c++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        if (nv < 4) vpos[nv] = c;
        nv++;
      end
      if (c == 19) rdy19 = o_ready;
      if (c == 38) rdy38 = o_ready;
      if (c == 50) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    checks++; if (nv != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nv); end
    checks++; if (vpos[0] != 18) begin errors++; $display("FAIL b2b_first got %0d want 18", vpos[0]); end
    checks++; if (vpos[1] != 37) begin errors++; $display("FAIL b2b_second got %0d want 37", vpos[1]); end
    checks++; if (vpos[2] != 56) begin errors++; $display("FAIL b2b_third got %0d want 56", vpos[2]); end
    checks++; if (rdy19 !== 1'b1 || rdy38 !== 1'b1) begin
      errors++; $display("FAIL b2b_idle_ready got %b%b want 11", rdy19, rdy38);
    end
  endtask

  task automatic test_reset_midrot();
    int nv = 0, rx, ry, lat;
    logic [AW-1:0] ra;
    @(negedge i_clk);
    i_valid = 1'b1; i_mag = 16'h7000; i_phase = 16'h3000; i_aux = 4'h9;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (8) @(negedge i_clk);
    i_reset = 1'b1; i_valid = 1'b1;  // reset must win over the request
    @(negedge i_clk);
    i_reset = 1'b0; i_valid = 1'b0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", o_valid); end
    checks++; if (o_x !== 16'sd0 || o_y !== 16'sd0) begin
      errors++; $display("FAIL rst_mid_xy got %0d,%0d want 0,0", o_x, o_y);
    end
    checks++; if (o_aux !== '0) begin errors++; $display("FAIL rst_mid_aux got %0h want 0", o_aux); end
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) nv++;
    end
    checks++; if (nv != 0) begin errors++; $display("FAIL rst_mid_dropped got %0d strobes want 0", nv); end
    run_req(16'h8000, 16'hC000, 4'h7, rx, ry, ra, lat);
    checks++;
    if (lat != 18) begin
      errors++; $display("FAIL rst_after_latency got %0d want 18", lat);
    end else begin
      checks++; if (rx < -3 || rx > 3 || ry < -16387 || ry > -16381) begin
        errors++; $display("FAIL rst_after_xy got %0d,%0d want 0,-16384 +-3", rx, ry);
      end
      checks++; if (ra !== 4'h7) begin errors++; $display("FAIL rst_after_aux got %0h want 7", ra); end
    end
  endtask

  task automatic test_zero_mag();
    logic [15:0] phs [5] = '{16'h1234, 16'h5A5A, 16'h9F01, 16'hFFFF, 16'hC000};
    int rx, ry, lat;
    logic [AW-1:0] ra;
    for (int k = 0; k < 5; k++) begin
      run_req(16'h0000, phs[k], AW'(k + 8), rx, ry, ra, lat);
      checks++;
      if (lat != 18 || rx != 0 || ry != 0) begin
        errors++; $display("FAIL zero%0d got lat %0d xy %0d,%0d want 18 0,0", k, lat, rx, ry);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] mags [2] = '{16'd400, 16'hFFFF};
    logic [15:0] starts [5] = '{16'h0000, 16'h3F00, 16'h7F00, 16'hBF00, 16'hFF00};
    int rx, ry, lat;
    logic [AW-1:0] ra;
    logic [15:0] ph;
    real ex, ey, ang, dph;
    for (int mi = 0; mi < 2; mi++) begin
      for (int si = 0; si < 5; si++) begin
        for (int k = 0; k < 40; k++) begin
          ph = starts[si] + 16'(10 * k);
          run_req(mags[mi], ph, 4'hC, rx, ry, ra, lat);
          checks++;
          if (lat != 18) begin
            errors++; $display("FAIL sweep_latency mag %0d ph %0h got %0d want 18", mags[mi], ph, lat);
            continue;
          end
          ex = (real'(mags[mi]) / 2.0) * $cos(2.0 * PI * real'(ph) / 65536.0);
          ey = (real'(mags[mi]) / 2.0) * $sin(2.0 * PI * real'(ph) / 65536.0);
          checks++;
          if (rabs(real'(rx) - ex) > 3.0 || rabs(real'(ry) - ey) > 3.0) begin
            errors++;
            $display("FAIL sweep_xy mag %0d ph %0h got %0d,%0d want %0.2f,%0.2f +-3", mags[mi], ph, rx, ry, ex, ey);
          end
          if (mags[mi] == 16'hFFFF) begin
            ang = $atan2(real'(ry), real'(rx)) * 65536.0 / (2.0 * PI);
            dph = ang - real'(ph);
            while (dph >= 32768.0) dph = dph - 65536.0;
            while (dph < -32768.0) dph = dph + 65536.0;
            checks++;
            if (rabs(dph) > 4.0) begin
              errors++; $display("FAIL sweep_phase ph %0h got %0.2f want %0d +-4", ph, ang, ph);
            end
          end
        end
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_mag = '0; i_phase = '0; i_aux = '0;
    test_reset();
    test_directed();
    test_latency_handshake();
    test_back_to_back();
    test_reset_midrot();
    test_zero_mag();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
